// File: rtl/ifm_pingpong_ctrl.sv
// Ping-pong IFM bank controller: fills one bank from the loader while replaying the other cfg_pass times.
// Optional reader-starvation counter enabled with `define IFM_PINGPONG_PERF_EN.
module ifm_pingpong_ctrl #(
    parameter int MAX_LEN = 4608,
    parameter int LEN_W   = 13,
    parameter int PASS_W  = 8,
    parameter int TILE_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [PASS_W-1:0] cfg_pass,
    input  logic [TILE_W-1:0] cfg_tiles,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              out_ready,
    output logic              out_valid,
    output logic              wr_clr_1,
    output logic              wr_clr_2,
    output logic              rd_clr_1,
    output logic              rd_clr_2,
    output logic              wr_en_1,
    output logic              wr_en_2,
    output logic              rd_en_1,
    output logic              rd_en_2,
    output logic              ifm_demux,
    output logic              ifm_mux,
    output logic              busy,
    output logic              done,
    output logic [31:0]       perf_stall_cnt
);

    typedef enum logic [1:0] {W_IDLE, W_CLR, W_FILL, W_DONE} w_state_t;
    typedef enum logic [2:0] {R_IDLE, R_CLR, R_READ, R_GAP, R_DONE} r_state_t;

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    w_state_t          w_state_q, w_state_d;
    r_state_t          r_state_q, r_state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic [TILE_W-1:0] tiles_q, tiles_d;
    logic [LEN_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [LEN_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [TILE_W-1:0] wr_tile_q, wr_tile_d;
    logic [TILE_W-1:0] rd_tile_q, rd_tile_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              out_valid_q, out_valid_d;

    logic              start_acc;
    logic              wr_fire;
    logic              rd_fire;
    logic              swap;
    logic              rd_parked;
    logic [PASS_W-1:0] pass_nxt;

    assign start_acc = start && !busy_q && (cfg_len != '0) && (cfg_pass != '0) && (cfg_tiles != '0);
    assign rd_parked = (r_state_q == R_IDLE) || (r_state_q == R_DONE);
    assign swap      = (w_state_q == W_DONE) && rd_parked;
    assign pass_nxt  = pass_cnt_q + PASS_W'(1);

    assign in_ready  = (w_state_q == W_FILL) && (wr_cnt_q < len_q);
    assign wr_fire   = in_valid && in_ready;
    assign rd_fire   = (r_state_q == R_READ) && out_ready;

    assign wr_en_1   = wr_fire && !wr_bank_q;
    assign wr_en_2   = wr_fire && wr_bank_q;
    assign rd_en_1   = rd_fire && !rd_bank_q;
    assign rd_en_2   = rd_fire && rd_bank_q;
    assign wr_clr_1  = (w_state_q == W_CLR) && !wr_bank_q;
    assign wr_clr_2  = (w_state_q == W_CLR) && wr_bank_q;
    assign rd_clr_1  = (r_state_q == R_CLR) && !rd_bank_q;
    assign rd_clr_2  = (r_state_q == R_CLR) && rd_bank_q;
    assign ifm_demux = wr_bank_q;
    assign ifm_mux   = rd_bank_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;

    always_comb begin
        w_state_d   = w_state_q;
        r_state_d   = r_state_q;
        len_d       = len_q;
        pass_d      = pass_q;
        tiles_d     = tiles_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        pass_cnt_d  = pass_cnt_q;
        wr_tile_d   = wr_tile_q;
        rd_tile_d   = rd_tile_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        out_valid_d = rd_en_1 || rd_en_2;

        if (start_acc) begin
            len_d      = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
            pass_d     = cfg_pass;
            tiles_d    = cfg_tiles;
            wr_cnt_d   = '0;
            rd_cnt_d   = '0;
            pass_cnt_d = '0;
            wr_tile_d  = TILE_W'(1);
            rd_tile_d  = '0;
            wr_bank_d  = 1'b0;
            rd_bank_d  = 1'b0;
            busy_d     = 1'b1;
            w_state_d  = W_CLR;
            r_state_d  = R_IDLE;
        end else begin
            case (w_state_q)
                W_CLR: begin
                    wr_cnt_d  = '0;
                    w_state_d = W_FILL;
                end
                W_FILL: begin
                    if (wr_fire) begin
                        wr_cnt_d = wr_cnt_q + LEN_W'(1);
                        if (wr_cnt_q == len_q - LEN_W'(1)) w_state_d = W_DONE;
                    end
                end
                default: ;
            endcase

            case (r_state_q)
                R_CLR: begin
                    rd_cnt_d  = '0;
                    r_state_d = R_READ;
                end
                R_READ: begin
                    if (rd_fire) begin
                        rd_cnt_d = rd_cnt_q + LEN_W'(1);
                        if (rd_cnt_q == len_q - LEN_W'(1)) r_state_d = R_GAP;
                    end
                end
                R_GAP: begin
                    pass_cnt_d = pass_nxt;
                    if (pass_nxt < pass_q) begin
                        r_state_d = R_CLR;
                    end else begin
                        r_state_d = R_DONE;
                        if (rd_tile_q == tiles_q) begin
                            done_d = 1'b1;
                            busy_d = 1'b0;
                        end
                    end
                end
                R_DONE: begin
                    if (!busy_q) r_state_d = R_IDLE;
                end
                default: ;
            endcase

            // Bank exchange: the just-filled bank becomes the replay bank.
            if (swap) begin
                rd_bank_d  = wr_bank_q;
                wr_bank_d  = !wr_bank_q;
                r_state_d  = R_CLR;
                pass_cnt_d = '0;
                rd_tile_d  = rd_tile_q + TILE_W'(1);
                if (wr_tile_q < tiles_q) begin
                    w_state_d = W_CLR;
                    wr_tile_d = wr_tile_q + TILE_W'(1);
                end else begin
                    w_state_d = W_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            len_q       <= '0;
            pass_q      <= '0;
            tiles_q     <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            pass_cnt_q  <= '0;
            wr_tile_q   <= '0;
            rd_tile_q   <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            len_q       <= len_d;
            pass_q      <= pass_d;
            tiles_q     <= tiles_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            pass_cnt_q  <= pass_cnt_d;
            wr_tile_q   <= wr_tile_d;
            rd_tile_q   <= rd_tile_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef IFM_PINGPONG_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Counts cycles the reader sits parked while the writer is still filling.
    always_comb begin
        perf_d = perf_q;
        if (start_acc) begin
            perf_d = '0;
        end else if (busy_q && rd_parked && (w_state_q != W_DONE) && (perf_q != '1)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) perf_q <= '0;
        else     perf_q <= perf_d;
    end

    assign perf_stall_cnt = perf_q;
`else
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ifm_pingpong_ctrl.sv
// Bench for ifm_pingpong_ctrl: directed and randomized jobs checked against a tile/pass timing model.
module tb_ifm_pingpong_ctrl;

    localparam int N = 16384;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [12:0] cfg_len;
    logic [7:0]  cfg_pass;
    logic [9:0]  cfg_tiles;
    logic        in_valid, in_ready, out_ready, out_valid;
    logic        wr_clr_1, wr_clr_2, rd_clr_1, rd_clr_2;
    logic        wr_en_1, wr_en_2, rd_en_1, rd_en_2;
    logic        ifm_demux, ifm_mux, busy, done;
    logic [31:0] perf_stall_cnt;

    int tests = 0;
    int fails = 0;

    bit iv_a [N];
    bit or_a [N];

    int m_done, m_stall, m_f0, m_swap0;

    always #5 clk = ~clk;

    ifm_pingpong_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_len(cfg_len), .cfg_pass(cfg_pass), .cfg_tiles(cfg_tiles),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_ready(out_ready), .out_valid(out_valid),
        .wr_clr_1(wr_clr_1), .wr_clr_2(wr_clr_2),
        .rd_clr_1(rd_clr_1), .rd_clr_2(rd_clr_2),
        .wr_en_1(wr_en_1), .wr_en_2(wr_en_2),
        .rd_en_1(rd_en_1), .rd_en_2(rd_en_2),
        .ifm_demux(ifm_demux), .ifm_mux(ifm_mux),
        .busy(busy), .done(done), .perf_stall_cnt(perf_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int nth_valid(int from, int n);
        int hits = 0;
        for (int c = from; c < N; c++) begin
            if (iv_a[c]) begin
                hits++;
                if (hits == n) return c;
            end
        end
        return N;
    endfunction

    function automatic int nth_ready(int from, int n);
        int hits = 0;
        for (int c = from; c < N; c++) begin
            if (or_a[c]) begin
                hits++;
                if (hits == n) return c;
            end
        end
        return N;
    endfunction

    // Job timeline in cycles relative to the start cycle (0): each tile needs a clear cycle
    // plus len accepted words; each pass needs a clear cycle, len ready cycles and a gap cycle.
    task automatic model(input int len, input int pass, input int tiles);
        int wclr, rfree, f, wdone, sw, c;
        wclr = 1; rfree = 1; m_stall = 0;
        for (int t = 0; t < tiles; t++) begin
            f     = nth_valid(wclr + 1, len);
            wdone = f + 1;
            if (wdone > rfree) m_stall += wdone - rfree;
            sw    = (wdone > rfree) ? wdone : rfree;
            if (t == 0) begin
                m_f0    = f;
                m_swap0 = sw;
            end
            c = sw + 1;
            for (int p = 0; p < pass; p++) c = nth_ready(c + 1, len) + 2;
            rfree = c;
            wclr  = sw + 1;
        end
        m_done = rfree;
    endtask

    task automatic fill_const(input bit v_iv, input bit v_or);
        for (int i = 0; i < N; i++) begin
            iv_a[i] = v_iv;
            or_a[i] = v_or;
        end
    endtask

    task automatic fill_rand(input int p_iv, input int p_or);
        for (int i = 0; i < N; i++) begin
            iv_a[i] = ($urandom_range(99) < p_iv);
            or_a[i] = ($urandom_range(99) < p_or);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {18'd0, in_ready, out_valid, wr_clr_1, wr_clr_2, rd_clr_1, rd_clr_2,
                wr_en_1, wr_en_2, rd_en_1, rd_en_2, ifm_demux, ifm_mux, busy, done};
    endfunction

    task automatic run_job(input string nm, input int len_raw, input int pass, input int tiles,
                           input int restart_at);
        int len, te, to, last, exp_perf, perf_done;
        int n_wr1, n_wr2, n_rd1, n_rd2, n_wc1, n_wc2, n_rc1, n_rc2, n_ov, n_done, done_at;
        int viol, ov_bad;
        bit prev_rd;
        len = (len_raw > 4608) ? 4608 : len_raw;
        model(len, pass, tiles);
        te = (tiles + 1) / 2;
        to = tiles / 2;
        last = m_done + 3;
`ifdef IFM_PINGPONG_PERF_EN
        exp_perf = m_stall;
`else
        exp_perf = 0;
`endif
        n_wr1 = 0; n_wr2 = 0; n_rd1 = 0; n_rd2 = 0; n_wc1 = 0; n_wc2 = 0;
        n_rc1 = 0; n_rc2 = 0; n_ov = 0; n_done = 0; done_at = -1;
        viol = 0; ov_bad = 0; prev_rd = 1'b0; perf_done = -1;
        for (int k = 0; k <= last; k++) begin
            start     = (k == 0) || (k == restart_at);
            cfg_len   = (k == 0) ? 13'(len_raw) : 13'd3;
            cfg_pass  = (k == 0) ? 8'(pass) : 8'd1;
            cfg_tiles = (k == 0) ? 10'(tiles) : 10'd1;
            in_valid  = iv_a[k];
            out_ready = or_a[k];
            #1;
            n_wr1 += int'(wr_en_1);  n_wr2 += int'(wr_en_2);
            n_rd1 += int'(rd_en_1);  n_rd2 += int'(rd_en_2);
            n_wc1 += int'(wr_clr_1); n_wc2 += int'(wr_clr_2);
            n_rc1 += int'(rd_clr_1); n_rc2 += int'(rd_clr_2);
            n_ov  += int'(out_valid);
            if ((wr_en_1 && rd_en_1) || (wr_en_2 && rd_en_2) ||
                (wr_en_1 && ifm_demux) || (wr_en_2 && !ifm_demux) ||
                (rd_en_1 && ifm_mux) || (rd_en_2 && !ifm_mux) ||
                ((rd_en_1 || rd_en_2) && !out_ready) || ((wr_en_1 || wr_en_2) && !in_valid))
                viol++;
            if (out_valid !== prev_rd) ov_bad++;
            prev_rd = rd_en_1 || rd_en_2;
            if (k == 1) begin
                chk({nm, "_first_wr_clr_1"}, 32'(wr_clr_1), 32'd1);
                chk({nm, "_busy_set"}, 32'(busy), 32'd1);
            end
            if (k == m_f0 + 1) chk({nm, "_in_ready_drop"}, 32'(in_ready), 32'd0);
            if (k == m_swap0 + 1) begin
                chk({nm, "_swap_demux"}, 32'(ifm_demux), 32'd1);
                chk({nm, "_swap_mux"}, 32'(ifm_mux), 32'd0);
            end
            if (k == m_done - 1) chk({nm, "_busy_before_done"}, 32'(busy), 32'd1);
            if (k == m_done) perf_done = int'(perf_stall_cnt);
            if (done === 1'b1) begin
                n_done++;
                if (done_at < 0) done_at = k;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        #1;
        chk({nm, "_wr_en_1"}, 32'(n_wr1), 32'(len * te));
        chk({nm, "_wr_en_2"}, 32'(n_wr2), 32'(len * to));
        chk({nm, "_rd_en_1"}, 32'(n_rd1), 32'(len * pass * te));
        chk({nm, "_rd_en_2"}, 32'(n_rd2), 32'(len * pass * to));
        chk({nm, "_wr_clr_1"}, 32'(n_wc1), 32'(te));
        chk({nm, "_wr_clr_2"}, 32'(n_wc2), 32'(to));
        chk({nm, "_rd_clr_1"}, 32'(n_rc1), 32'(pass * te));
        chk({nm, "_rd_clr_2"}, 32'(n_rc2), 32'(pass * to));
        chk({nm, "_out_valid"}, 32'(n_ov), 32'(len * pass * tiles));
        chk({nm, "_done_pulses"}, 32'(n_done), 32'd1);
        chk({nm, "_done_cycle"}, 32'(done_at), 32'(m_done));
        chk({nm, "_isolation"}, 32'(viol), 32'd0);
        chk({nm, "_ov_delay"}, 32'(ov_bad), 32'd0);
        chk({nm, "_perf_at_done"}, 32'(perf_done), 32'(exp_perf));
        chk({nm, "_perf_hold"}, perf_stall_cnt, 32'(exp_perf));
        chk({nm, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    task automatic bad_start(input string nm, input int len, input int pass, input int tiles);
        start = 1'b1; cfg_len = 13'(len); cfg_pass = 8'(pass); cfg_tiles = 10'(tiles);
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_no_clr"}, 32'(wr_clr_1), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        bit hit;
        int ndone;
        rst = 1'b1; start = 1'b0; cfg_len = '0; cfg_pass = '0; cfg_tiles = '0;
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_outputs", out_vec(), 32'd0);
        chk("reset_perf", perf_stall_cnt, 32'd0);

        fill_const(1'b1, 1'b1);
        run_job("basic", 4, 2, 2, -1);

        for (int i = 0; i < N; i++) iv_a[i] = (i % 2 == 1);
        run_job("up_stall", 6, 1, 1, -1);

        fill_const(1'b1, 1'b1);
        or_a[12] = 1'b0; or_a[13] = 1'b0; or_a[14] = 1'b0;
        run_job("backpr", 6, 2, 1, -1);

        bad_start("bad_pass", 4, 0, 2);
        bad_start("bad_len", 0, 1, 1);
        bad_start("bad_tiles", 4, 1, 0);

        fill_const(1'b1, 1'b1);
        run_job("busy_start", 5, 2, 3, 5);

        for (int i = 0; i < N; i++) iv_a[i] = (i % 2 == 1);
        run_job("perf", 8, 1, 2, -1);

        // Abort during the first replay, then confirm a clean restart.
        fill_const(1'b1, 1'b1);
        start = 1'b1; cfg_len = 13'd4; cfg_pass = 8'd2; cfg_tiles = 10'd2;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            #1;
            if (rd_en_1 === 1'b1) hit = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("rst_reached_read", 32'(hit), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_outputs", out_vec(), 32'd0);
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #2;
            ndone += int'(done);
        end
        chk("rst_no_done", 32'(ndone), 32'd0);
        @(posedge clk); #1;
        run_job("after_rst", 3, 1, 2, -1);

        fill_const(1'b1, 1'b1);
        run_job("clamp", 5000, 1, 1, -1);

        for (int j = 0; j < 6; j++) begin
            fill_rand(65, 60);
            run_job($sformatf("rand%0d", j), int'($urandom_range(1, 10)),
                    int'($urandom_range(1, 3)), int'($urandom_range(1, 4)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
